registers_bank_dumper: RTL and testbench
========================================

// Module: registers_bank_dumper
// PURPOSE
//   Debug-side reader of the ID stage's flattened register-bank bus (o_bus_debug).
//   On a start request it snapshots all registers.
//   It then streams the snapshot out as bytes over a valid/ready interface to the
//   debug transmitter (UART TX path), so the host can read the full register state.
//   The pipeline may keep running during a dump because the snapshot isolates it.
// PARAMETERS
//   REGISTERS_BANK_SIZE  32  number of registers in the flattened bus
//   BUS_SIZE             32  register width in bits; must be a multiple of 8
// PORTS
//   i_clk        in   1                         clock; all logic on rising edge
//   i_reset      in   1                         asynchronous, active-low reset
//   i_start      in   1                         dump request; sampled only in IDLE
//   i_bus_debug  in   REGISTERS_BANK_SIZE*BUS_SIZE  flattened bank; reg k at [k*BUS_SIZE +: BUS_SIZE]
//   i_tx_ready   in   1                         downstream can accept a byte this cycle
//   o_tx_data    out  8                         byte being offered
//   o_tx_valid   out  1                         o_tx_data is valid
//   o_busy       out  1                         dump in progress (not IDLE)
//   o_done       out  1                         1-cycle pulse after the last byte is accepted
// BEHAVIOUR
//   Reset (i_reset=0, any time, async): state=IDLE, o_tx_data=0, o_tx_valid=0, o_busy=0,
//     o_done=0, counters=0, snapshot=0. A dump interrupted by reset is abandoned and never resumed.
//   FSM states: IDLE -> SEND -> DONE -> IDLE.
//   IDLE: if i_start=1 at edge N, latch the whole i_bus_debug into the snapshot, clear
//     reg_idx/byte_idx, and go to SEND. o_tx_valid=1 and o_busy=1 from cycle N+1.
//   SEND: o_tx_data = byte byte_idx of snapshot reg reg_idx.
//     Bytes are sent MSB first: byte 0 = bits [BUS_SIZE-1 -: 8].
//     Registers go in ascending order, 0 .. REGISTERS_BANK_SIZE-1.
//   Handshake: a transfer occurs on an edge where o_tx_valid && i_tx_ready.
//     While valid && !ready, o_tx_data and o_tx_valid hold stable; no byte is skipped or repeated.
//     On each transfer, byte_idx increments. At BUS_SIZE/8-1 it wraps to 0 and reg_idx increments.
//     The transfer of the last byte (last reg, last byte) moves the FSM to DONE.
//     With ready held high, one byte is accepted per cycle with no bubbles.
//   DONE: lasts exactly 1 cycle. o_tx_valid=0, o_done=1, o_busy=1; then IDLE, where o_done=0 and o_busy=0.
//   i_start while not IDLE is ignored; it is neither queued nor allowed to restart.
//     A new dump may start on the first IDLE cycle.
//   i_bus_debug changes after the snapshot edge have no effect on the bytes emitted.
//   Total bytes per dump = REGISTERS_BANK_SIZE*BUS_SIZE/8 (128 with defaults).
//   Counter widths:
//     reg_idx  = $clog2(REGISTERS_BANK_SIZE)
//     byte_idx = max(1, $clog2(BUS_SIZE/8))
//     With BUS_SIZE=8, byte_idx stays 0.
//   o_tx_data, o_tx_valid, o_busy and o_done are registered outputs; no combinational path from i_tx_ready.
// TESTING
//   1 Reset: hold i_reset=0 with i_start=1 and i_tx_ready=1.
//     -> all outputs 0 and stay 0. Release reset -> still IDLE until i_start is sampled.
//   2 Full dump, ready=1: reg k = 32'hA000_0000+k; pulse i_start at edge N.
//     -> from cycle N+1, 128 consecutive bytes A0 00 00 00 A0 00 00 01 ... A0 00 00 1F.
//     -> o_done=1 for exactly one cycle at N+129; o_busy falls at N+130.
//   3 Backpressure: same data, i_tx_ready pseudo-random at ~50%.
//     -> identical 128-byte sequence; o_tx_data is stable during every stall; no duplicates or drops.
//   4 Snapshot isolation: after the start edge, overwrite all i_bus_debug with 32'hFFFF_FFFF.
//     -> the stream still carries the original A0 00 00 xx values.
//   5 Start while busy: pulse i_start at bytes 10 and 127.
//     -> a single 128-byte dump and one o_done. A start on the first IDLE cycle after DONE launches a new dump.
//   6 Reset mid-dump: assert i_reset=0 asynchronously after byte 50.
//     -> outputs go to 0 immediately. After release plus i_start, the new dump begins at reg 0 byte 0.

Source files
------------

// File: rtl/registers_bank_dumper.sv
// -----------------------------------------------------------------------------
// registers_bank_dumper
//   Debug-side reader of the ID stage's flattened register-bank bus. A start
//   request taken in IDLE snapshots the entire bank. The snapshot is then
//   streamed out one byte at a time over a valid/ready interface toward the
//   debug UART transmitter. Because the snapshot is private, the pipeline may
//   keep running and changing the bank while a dump is in progress.
//
//   Stream order: registers 0 .. REGISTERS_BANK_SIZE-1, and within each
//   register the most significant byte first.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_reset      asynchronous active-low reset
//   i_start      dump request, sampled only while idle
//   i_bus_debug  flattened bank, register k at [k*BUS_SIZE +: BUS_SIZE]
//   i_tx_ready   downstream accepts o_tx_data this cycle
//   o_tx_data    byte being offered (registered)
//   o_tx_valid   o_tx_data is valid (registered)
//   o_busy       dump in progress, high outside IDLE (registered)
//   o_done       one-cycle pulse after the last byte is accepted (registered)
// -----------------------------------------------------------------------------
module registers_bank_dumper #(
   parameter int REGISTERS_BANK_SIZE = 32,
   parameter int BUS_SIZE            = 32
) (
   input  logic                                  i_clk,
   input  logic                                  i_reset,
   input  logic                                  i_start,
   input  logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0] i_bus_debug,
   input  logic                                  i_tx_ready,
   output logic [7:0]                            o_tx_data,
   output logic                                  o_tx_valid,
   output logic                                  o_busy,
   output logic                                  o_done
);

   localparam int TOTAL_W       = REGISTERS_BANK_SIZE * BUS_SIZE;
   localparam int BYTES_PER_REG = BUS_SIZE / 8;
   localparam int REG_IDX_W     = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1;
   localparam int BYTE_IDX_W    = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
   // One extra bit so the highest bit position always fits.
   localparam int POS_W         = $clog2(TOTAL_W) + 1;

   localparam logic [REG_IDX_W-1:0]  LAST_REG  = REG_IDX_W'(REGISTERS_BANK_SIZE - 1);
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_REG - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  r_state;
   logic [TOTAL_W-1:0]      r_snapshot;
   logic [REG_IDX_W-1:0]    r_reg_idx;
   logic [BYTE_IDX_W-1:0]   r_byte_idx;
   logic [7:0]              r_tx_data;
   logic                    r_tx_valid;
   logic                    r_busy;
   logic                    r_done;

   logic                    w_last_byte_of_reg;
   logic                    w_last_transfer;
   logic [REG_IDX_W-1:0]    w_next_reg_idx;
   logic [BYTE_IDX_W-1:0]   w_next_byte_idx;
   logic [7:0]              w_next_byte;
   logic [7:0]              w_first_byte;

   // Byte byte_i of register reg_i, byte 0 being the register's top byte.
   function automatic logic [7:0] f_pick_byte(
      input logic [TOTAL_W-1:0]    bank,
      input logic [REG_IDX_W-1:0]  reg_i,
      input logic [BYTE_IDX_W-1:0] byte_i
   );
      logic [POS_W-1:0] pos;
      pos = POS_W'(reg_i) * POS_W'(BUS_SIZE) + POS_W'(BUS_SIZE - 1) - (POS_W'(byte_i) << 3);
      return bank[pos -: 8];
   endfunction

   // Next byte/register position and the byte that will be offered there.
   // The next byte is prepared ahead so o_tx_data can stay a plain register.
   always_comb begin
      w_last_byte_of_reg = (r_byte_idx == LAST_BYTE);
      w_last_transfer    = w_last_byte_of_reg && (r_reg_idx == LAST_REG);
      w_next_reg_idx     = r_reg_idx;
      w_next_byte_idx    = r_byte_idx;
      if (w_last_byte_of_reg) begin
         w_next_byte_idx = '0;
         w_next_reg_idx  = r_reg_idx + REG_IDX_W'(1);
      end else begin
         w_next_byte_idx = r_byte_idx + BYTE_IDX_W'(1);
         w_next_reg_idx  = r_reg_idx;
      end
      w_next_byte  = f_pick_byte(r_snapshot, w_next_reg_idx, w_next_byte_idx);
      // First byte comes straight from the live bus on the snapshot edge.
      w_first_byte = f_pick_byte(i_bus_debug, '0, '0);
   end

   // Dump FSM with snapshot, position counters and registered outputs.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= ST_IDLE;
         r_snapshot <= '0;
         r_reg_idx  <= '0;
         r_byte_idx <= '0;
         r_tx_data  <= 8'h00;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_snapshot <= i_bus_debug;
                  r_reg_idx  <= '0;
                  r_byte_idx <= '0;
                  r_tx_data  <= w_first_byte;
                  r_tx_valid <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ST_SEND;
               end else begin
                  r_tx_data  <= 8'h00;
                  r_tx_valid <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            ST_SEND: begin
               // r_tx_valid is always high here, so ready alone means transfer.
               if (i_tx_ready) begin
                  if (w_last_transfer) begin
                     r_reg_idx  <= '0;
                     r_byte_idx <= '0;
                     r_tx_data  <= 8'h00;
                     r_tx_valid <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= ST_DONE;
                  end else begin
                     r_reg_idx  <= w_next_reg_idx;
                     r_byte_idx <= w_next_byte_idx;
                     r_tx_data  <= w_next_byte;
                     r_tx_valid <= 1'b1;
                     r_done     <= 1'b0;
                     r_state    <= ST_SEND;
                  end
               end else begin
                  // Stall: hold the offered byte and position.
                  r_tx_data  <= r_tx_data;
                  r_tx_valid <= r_tx_valid;
                  r_state    <= ST_SEND;
               end
            end
            ST_DONE: begin
               r_done     <= 1'b0;
               r_busy     <= 1'b0;
               r_tx_valid <= 1'b0;
               r_tx_data  <= 8'h00;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_reg_idx  <= '0;
               r_byte_idx <= '0;
               r_tx_data  <= 8'h00;
               r_tx_valid <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   assign o_tx_data  = r_tx_data;
   assign o_tx_valid = r_tx_valid;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule

// File: tb/tb_registers_bank_dumper.sv
// -----------------------------------------------------------------------------
// tb_registers_bank_dumper
//   Directed self-checking bench for registers_bank_dumper with default
//   parameters (32 registers of 32 bits, 128 bytes per dump). Inputs are
//   driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_registers_bank_dumper;

   localparam int NREG   = 32;
   localparam int BW     = 32;
   localparam int NBYTES = NREG * BW / 8;

   localparam int MODE_READY    = 0;
   localparam int MODE_RANDOM   = 1;
   localparam int MODE_ISOLATE  = 2;
   localparam int MODE_STARTBSY = 3;

   logic                 clk;
   logic                 reset_n;
   logic                 start;
   logic [NREG*BW-1:0]   bus_debug;
   logic                 tx_ready;
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 busy;
   logic                 done;

   int n_checks;
   int n_errors;

   registers_bank_dumper #(
      .REGISTERS_BANK_SIZE (NREG),
      .BUS_SIZE            (BW)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset_n),
      .i_start     (start),
      .i_bus_debug (bus_debug),
      .i_tx_ready  (tx_ready),
      .o_tx_data   (tx_data),
      .o_tx_valid  (tx_valid),
      .o_busy      (busy),
      .o_done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Register k holds 32'hA000_0000 + k, top byte first in the stream.
   function automatic logic [7:0] exp_byte(input int idx);
      logic [31:0] v;
      int          r;
      int          b;
      r = idx / 4;
      b = idx % 4;
      v = 32'hA000_0000 + 32'(r);
      return v[31 - 8*b -: 8];
   endfunction

   task automatic load_pattern();
      for (int k = 0; k < NREG; k++) begin
         bus_debug[k*BW +: BW] = 32'hA000_0000 + 32'(k);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_value({tag, "_data"},  32'(tx_data),  32'd0);
      check_value({tag, "_valid"}, 32'(tx_valid), 32'd0);
      check_value({tag, "_busy"},  32'(busy),     32'd0);
      check_value({tag, "_done"},  32'(done),     32'd0);
   endtask

   // One complete dump started from IDLE at the current falling edge.
   task automatic run_dump(input int mode);
      int         idx;
      int         cycles;
      logic       stalled;
      logic [7:0] held;
      idx     = 0;
      cycles  = 0;
      stalled = 1'b0;
      held    = 8'h00;
      start    = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (mode == MODE_ISOLATE) bus_debug = '1;
      check_value("busy_after_start", 32'(busy), 32'd1);
      while (idx < NBYTES && cycles < 4000) begin
         check_value("valid_in_send", 32'(tx_valid), 32'd1);
         check_value("done_in_send",  32'(done),     32'd0);
         if (stalled) check_value("stall_hold", 32'(tx_data), 32'(held));
         tx_ready = (mode == MODE_RANDOM) ? 1'($urandom_range(0, 1)) : 1'b1;
         start    = (mode == MODE_STARTBSY && (idx == 10 || idx == 127)) ? 1'b1 : 1'b0;
         if (tx_valid && tx_ready) begin
            check_value($sformatf("byte%0d", idx), 32'(tx_data), 32'(exp_byte(idx)));
            idx++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held    = tx_data;
         end
         cycles++;
         @(negedge clk);
      end
      start    = 1'b0;
      tx_ready = 1'b1;
      if (idx != NBYTES) check_value("dump_timeout", 32'(idx), 32'(NBYTES));
      check_value("done_pulse",  32'(done),     32'd1);
      check_value("done_valid",  32'(tx_valid), 32'd0);
      check_value("done_busy",   32'(busy),     32'd1);
      @(negedge clk);
      check_value("after_done",  32'(done),     32'd0);
      check_value("after_busy",  32'(busy),     32'd0);
      check_value("after_valid", 32'(tx_valid), 32'd0);
      if (mode == MODE_ISOLATE) load_pattern();
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset_n   = 1'b0;
      start     = 1'b1;
      tx_ready  = 1'b1;
      bus_debug = '0;
      load_pattern();

      // Reset held with start and ready asserted: everything stays zero.
      repeat (3) begin
         @(negedge clk);
         check_idle_outputs("in_reset");
      end
      start   = 1'b0;
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_idle_outputs("post_reset");
      end

      run_dump(MODE_READY);
      run_dump(MODE_RANDOM);
      run_dump(MODE_ISOLATE);
      run_dump(MODE_STARTBSY);
      // Starts on the first IDLE cycle after DONE.
      run_dump(MODE_READY);

      // Reset in the middle of a dump, then a fresh dump from reg 0 byte 0.
      start    = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (51) @(negedge clk);
      check_value("mid_dump_byte", 32'(tx_data), 32'(exp_byte(51)));
      #2;
      reset_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      @(negedge clk);
      check_idle_outputs("held_reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("released");
      run_dump(MODE_READY);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
